// File: rtl/sort_drain.sv
// Deskews a staggered sorter output into whole frames, buffers them in a small
// circular FIFO, and drains each frame one element per handshake in rank order.
package sort_pkg;
   localparam int W = 4;
   localparam int N = 8;
endpackage

module sort_drain #(
   parameter int W      = sort_pkg::W,
   parameter int N      = sort_pkg::N,
   parameter int FDEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_valid,
   input  logic [W-1:0][N-1:0]                  i_y_q,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic [N-1:0]                         o_data,
   output logic [((W > 1) ? $clog2(W) : 1)-1:0] o_idx,
   output logic                                 o_last,
   output logic                                 o_ovf,
   output logic                                 o_err
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int CW = $clog2(FDEPTH + 1);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   logic [W-1:0][N-1:0] aligned;
   logic                dvalid;

   // Lane l arrives l cycles late, so it needs W-1-l stages to line up with lane W-1.
   for (genvar l = 0; l < W; l++) begin : g_lane
      localparam int D = W - 1 - l;
      if (D == 0) begin : g_pass
         assign aligned[l] = i_y_q[l];
      end else begin : g_dly
         logic [D-1:0][N-1:0] sh_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sh_q <= '0;
            end else begin
               sh_q[0] <= i_y_q[l];
               for (int s = 1; s < D; s++) sh_q[s] <= sh_q[s-1];
            end
         end
         assign aligned[l] = sh_q[D-1];
      end
   end

   if (W > 1) begin : g_vpipe
      logic [W-2:0] vld_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= i_valid;
            for (int s = 1; s < W - 1; s++) vld_q[s] <= vld_q[s-1];
         end
      end
      assign dvalid = vld_q[W-2];
   end else begin : g_vpass
      assign dvalid = i_valid;
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [FDEPTH-1:0][W-1:0][N-1:0] mem_q;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   state_t        state_q, state_d;
   logic          ovf_q, ovf_d, err_q, err_d;
   logic          hs, at_last, pop, full, wr_en;

   always_comb begin
      hs       = (state_q == SEND) && i_ready;
      at_last  = (idx_q == IW'(W - 1));
      pop      = hs && at_last;
      full     = (cnt_q == CW'(FDEPTH));
      // A final-element pop frees the head slot in time for a write on the same edge.
      wr_en    = dvalid && (!full || pop);
      ovf_d    = dvalid && full && !pop;
      err_d    = err_q | ovf_q;
      wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
      idx_d    = idx_q;
      if (hs) idx_d = at_last ? '0 : idx_q + IW'(1);
      state_d  = (cnt_d != '0) ? SEND : IDLE;
      if (state_d == IDLE) idx_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         state_q  <= IDLE;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         state_q  <= state_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   // Frame storage carries no reset; o_data is gated so stale contents never show.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= aligned;
   end

   assign o_valid = (state_q == SEND);
   assign o_data  = o_valid ? mem_q[rd_ptr_q][idx_q] : '0;
   assign o_idx   = idx_q;
   assign o_last  = o_valid && at_last;
   assign o_ovf   = ovf_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_sort_drain.sv
// Directed-vector bench for sort_drain at W=4, N=8, FDEPTH=2; cycle 0 is the
// first cycle after reset release, inputs change just after each rising edge.
module tb_sort_drain;
   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            i_valid = 1'b0;
   logic [3:0][7:0] i_y_q = '0;
   logic            i_ready = 1'b0;
   logic            o_valid;
   logic [7:0]      o_data;
   logic [1:0]      o_idx;
   logic            o_last;
   logic            o_ovf;
   logic            o_err;

   int vec = 0;
   int bad = 0;

   int         nfr;
   int         fs [0:3];
   logic [7:0] fv [0:3][0:3];

   sort_drain #(.W(4), .N(8), .FDEPTH(2)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_y_q(i_y_q),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx),
      .o_last(o_last), .o_ovf(o_ovf), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; i_valid = 1'b0; i_y_q = '0; i_ready = 1'b0; nfr = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic add_frame(input int s, input logic [7:0] a, b, c, d);
      fs[nfr] = s;
      fv[nfr][0] = a; fv[nfr][1] = b; fv[nfr][2] = c; fv[nfr][3] = d;
      nfr++;
   endtask

   // Lane l of a frame started at cycle s is presented at cycle s+l.
   task automatic drive(input int c);
      i_valid = 1'b0;
      i_y_q   = '0;
      for (int f = 0; f < nfr; f++) begin
         if (fs[f] == c) i_valid = 1'b1;
         for (int l = 0; l < 4; l++)
            if (c - fs[f] == l) i_y_q[l] = fv[f][l];
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got %b exp 0", o_valid); end
      vec++; if (o_data !== 8'h00) begin bad++; $display("FAIL rst_async_data got %h exp 00", o_data); end
      vec++; if (o_idx !== 2'd0) begin bad++; $display("FAIL rst_async_idx got %0d exp 0", o_idx); end
      vec++; if (o_last !== 1'b0) begin bad++; $display("FAIL rst_async_last got %b exp 0", o_last); end
      vec++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL rst_async_ovf got %b exp 0", o_ovf); end
      vec++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_async_err got %b exp 0", o_err); end
      i_valid = 1'b1; i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_held_valid got %b exp 0", o_valid); end
      vec++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_held_err got %b exp 0", o_err); end
      i_valid = 1'b0;
   endtask

   task automatic test_single();
      int ed [0:9];
      int ei [0:9];
      ed = '{-1, -1, -1, -1, 'hF0, 'hA0, 'h50, 'h10, -1, -1};
      ei = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0};
      do_reset();
      add_frame(0, 8'hF0, 8'hA0, 8'h50, 8'h10);
      i_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         drive(c);
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL single_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL single_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
            vec++; if (o_idx !== 2'(ei[c])) begin bad++; $display("FAIL single_idx c=%0d got %0d exp %0d", c, o_idx, ei[c]); end
         end
         vec++; if (o_last !== (c == 7)) begin bad++; $display("FAIL single_last c=%0d got %b exp %b", c, o_last, c == 7); end
         vec++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf c=%0d got %b exp 0", c, o_ovf); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int ed [0:11];
      int ei [0:11];
      ed = '{-1, -1, -1, -1, 'hF0, 'hA0, 'hA0, 'hA0, 'h50, 'h10, -1, -1};
      ei = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 3, 0, 0};
      do_reset();
      add_frame(0, 8'hF0, 8'hA0, 8'h50, 8'h10);
      for (int c = 0; c < 12; c++) begin
         drive(c);
         i_ready = !(c == 5 || c == 6);
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL bp_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL bp_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
            vec++; if (o_idx !== 2'(ei[c])) begin bad++; $display("FAIL bp_idx c=%0d got %0d exp %0d", c, o_idx, ei[c]); end
         end
         vec++; if (o_last !== (c == 9)) begin bad++; $display("FAIL bp_last c=%0d got %b exp %b", c, o_last, c == 9); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int ed [0:13];
      ed = '{-1, -1, -1, -1, 'hF0, 'hA0, 'h50, 'h10, 'h99, 'h77, 'h33, 'h01, -1, -1};
      do_reset();
      add_frame(0, 8'hF0, 8'hA0, 8'h50, 8'h10);
      add_frame(4, 8'h99, 8'h77, 8'h33, 8'h01);
      i_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         drive(c);
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL b2b_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
            vec++; if (o_idx !== 2'((c - 4) % 4)) begin bad++; $display("FAIL b2b_idx c=%0d got %0d exp %0d", c, o_idx, (c - 4) % 4); end
         end
         vec++; if (o_last !== (c == 7 || c == 11)) begin bad++; $display("FAIL b2b_last c=%0d got %b exp %b", c, o_last, c == 7 || c == 11); end
         vec++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf c=%0d got %b exp 0", c, o_ovf); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_overflow();
      int ed [0:19];
      int ei [0:19];
      ed = '{-1, -1, -1, -1, 'h44, 'h44, 'h44, 'h44, 'h44, 'h44,
             'h44, 'h33, 'h22, 'h11, 'h88, 'h77, 'h66, 'h55, -1, -1};
      ei = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
      do_reset();
      add_frame(0, 8'h44, 8'h33, 8'h22, 8'h11);
      add_frame(1, 8'h88, 8'h77, 8'h66, 8'h55);
      add_frame(2, 8'hCC, 8'hBB, 8'hAA, 8'h99);
      for (int c = 0; c < 20; c++) begin
         drive(c);
         i_ready = (c >= 10);
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL ovf_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL ovf_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
            vec++; if (o_idx !== 2'(ei[c])) begin bad++; $display("FAIL ovf_idx c=%0d got %0d exp %0d", c, o_idx, ei[c]); end
         end
         vec++; if (o_last !== (c == 13 || c == 17)) begin bad++; $display("FAIL ovf_last c=%0d got %b exp %b", c, o_last, c == 13 || c == 17); end
         vec++; if (o_ovf !== (c == 6)) begin bad++; $display("FAIL ovf_pulse c=%0d got %b exp %b", c, o_ovf, c == 6); end
         vec++; if (o_err !== (c >= 7)) begin bad++; $display("FAIL ovf_err c=%0d got %b exp %b", c, o_err, c >= 7); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_full_pop();
      int ed [0:17];
      ed = '{-1, -1, -1, -1, 'hF0, 'hA0, 'h50, 'h10, 'hE1, 'hC1, 'h81, 'h41,
             'hD2, 'hB2, 'h92, 'h72, -1, -1};
      do_reset();
      add_frame(0, 8'hF0, 8'hA0, 8'h50, 8'h10);
      add_frame(1, 8'hE1, 8'hC1, 8'h81, 8'h41);
      add_frame(4, 8'hD2, 8'hB2, 8'h92, 8'h72);
      i_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         drive(c);
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL fpop_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL fpop_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
            vec++; if (o_idx !== 2'((c - 4) % 4)) begin bad++; $display("FAIL fpop_idx c=%0d got %0d exp %0d", c, o_idx, (c - 4) % 4); end
         end
         vec++; if (o_last !== (c == 7 || c == 11 || c == 15)) begin bad++; $display("FAIL fpop_last c=%0d got %b", c, o_last); end
         vec++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL fpop_ovf c=%0d got %b exp 0", c, o_ovf); end
         vec++; if (o_err !== 1'b0) begin bad++; $display("FAIL fpop_err c=%0d got %b exp 0", c, o_err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      int ed [0:17];
      ed = '{-1, -1, -1, -1, 'hF0, -1, -1, -1, -1, -1, -1, -1, -1, -1,
             'h5A, 'h4B, 'h3C, 'h2D};
      do_reset();
      add_frame(0, 8'hF0, 8'hA0, 8'h50, 8'h10);
      add_frame(10, 8'h5A, 8'h4B, 8'h3C, 8'h2D);
      i_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         drive(c);
         if (c == 5) begin
            #2 rst = 1'b1;
            #1;
            vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b exp 0", o_valid); end
            vec++; if (o_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got %h exp 00", o_data); end
            vec++; if (o_idx !== 2'd0) begin bad++; $display("FAIL mid_rst_idx got %0d exp 0", o_idx); end
         end
         if (c == 6) rst = 1'b0;
         @(negedge clk);
         vec++; if (o_valid !== (ed[c] >= 0)) begin bad++; $display("FAIL mid_valid c=%0d got %b exp %b", c, o_valid, ed[c] >= 0); end
         if (ed[c] >= 0) begin
            vec++; if (o_data !== 8'(ed[c])) begin bad++; $display("FAIL mid_data c=%0d got %h exp %h", c, o_data, 8'(ed[c])); end
         end
         vec++; if (o_last !== (c == 17)) begin bad++; $display("FAIL mid_last c=%0d got %b exp %b", c, o_last, c == 17); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/sort_drain.md
SORT_DRAIN -- requirements
Module: sort_drain

Interface
REQ-001 Parameter W, default sort_pkg::W: number of sorted lanes per frame, W >= 1.
REQ-002 Parameter N, default sort_pkg::N: element width in bits.
REQ-003 Parameter FDEPTH, default 2: frame buffer depth in frames, FDEPTH >= 1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  frame start, aligned with lane 0 of i_y_q.
REQ-007 i_y_q  input  [W-1:0][N-1:0]  staggered sorter output; lane i (rank i, 0 = max) valid i cycles after i_valid.
REQ-008 o_valid  output  1  element available on o_data.
REQ-009 i_ready  input  1  downstream accepts element when o_valid && i_ready.
REQ-010 o_data  output  N  current element.
REQ-011 o_idx  output  $clog2(W) (min 1)  rank of o_data within frame.
REQ-012 o_last  output  1  high with o_valid when o_idx == W-1.
REQ-013 o_ovf  output  1  one-cycle pulse, frame dropped.
REQ-014 o_err  output  1  sticky overflow flag.

Function
REQ-015 Deskew: lane i delayed by W-1-i registers; i_valid delayed by W-1 registers; all lanes of one frame aligned at the delayed-valid cycle.
REQ-016 Aligned frame written into the frame buffer on the edge ending the delayed-valid cycle; earliest o_valid is the cycle k+W when i_valid was high in cycle k.
REQ-017 Frame buffer: circular FIFO of FDEPTH frames, W x N bits each, write/read pointers wrap modulo FDEPTH, occupancy counter 0..FDEPTH.
REQ-018 Serializer states: IDLE (o_valid=0) and SEND (o_valid=1).
REQ-019 IDLE -> SEND on the cycle after buffer becomes non-empty; idx set to 0.
REQ-020 In SEND, o_data = head_frame[idx], o_idx = idx; on handshake idx increments.
REQ-021 Handshake with idx == W-1: head frame popped; stay SEND with idx=0 if another frame remains (no bubble), else IDLE.
REQ-022 o_data, o_idx, o_last held stable while o_valid && !i_ready.
REQ-023 Elements of a frame emitted in rank order 0..W-1 (descending value); frames emitted in arrival order.
REQ-024 Write when buffer full and no pop in the same cycle: frame discarded, buffer unchanged, o_ovf=1 for that cycle, o_err set.
REQ-025 Write and final-element pop in the same cycle while full: both take effect, no overflow.
REQ-026 Write into empty buffer with serializer IDLE: no data bypass; frame emitted next cycle per REQ-019.
REQ-027 i_valid may be high on consecutive cycles; each high cycle is a separate frame; lanes of overlapping frames never mix.
REQ-028 Sustained throughput: one frame per W handshakes; excess input frames overflow per REQ-024.
REQ-029 W == 1: no deskew registers, o_idx constant 0, o_last = o_valid.

Reset
REQ-030 rst high: deskew pipe, valid pipe, buffer pointers, occupancy, state, idx cleared immediately, irrespective of clk.
REQ-031 During and after reset: o_valid=0, o_data=0, o_idx=0, o_last=0, o_ovf=0, o_err=0.
REQ-032 Reset mid-frame or mid-pipe: in-flight and buffered frames discarded; no partial frame emitted after release.
REQ-033 o_err cleared only by rst.

Verification (W=4, N=8, FDEPTH=2)
REQ-034 Single frame: i_valid at cycle 0, lanes 0..3 = 0xF0,0xA0,0x50,0x10 at cycles 0..3, i_ready=1 -> o_valid cycles 4..7, o_data F0,A0,50,10, o_idx 0..3, o_last cycle 7 only.
REQ-035 Backpressure: same frame, i_ready low cycles 5-6 -> o_data holds 0xA0, o_idx=1 through cycle 7; all four elements emitted in order, last at cycle 9.
REQ-036 Back-to-back: frames at cycles 0 and 4, i_ready=1 -> eight contiguous o_valid cycles 4..11, no bubble, o_last at cycles 7 and 11.
REQ-037 Overflow: i_ready=0, i_valid at cycles 0,1,2 -> frames 0,1 buffered; o_ovf pulses at cycle 6, o_err=1 from cycle 7; after i_ready=1 only frames 0 and 1 emitted.
REQ-038 Full plus pop: buffer full, final handshake of head frame in the same cycle a new frame is written -> no o_ovf, new frame emitted after the remaining frame.
REQ-039 Reset mid-operation: rst pulsed at cycle 5 of REQ-034 -> o_valid=0 immediately; no output after release until a new i_valid frame.
